bus_interconnect: RTL and testbench

Parametrised memory-bus interconnect that replaces the hard-coded casez decode and OR-reduced read/ready mux in the SoC top level. It sits between the bus arbiter's common memory bus and N_SLAVES peripherals, and does three things: decodes the address against a base/mask map, drives a one-hot slave select, and returns the slave's read data and ready. A miss, or a slave that stalls too long, is converted into a ready+fault response.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_addr_decode.sv | 32 +++
 rtl/bus_interconnect.sv | 136 +++++++++++++
 tb/tb_bus_interconnect.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the memory-bus interconnect.
// The optional timeout path is selected by the BUS_TIMEOUT_EN macro; see bus_interconnect.sv.
package bus_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} bus_state_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = 4;

    // Bits needed to hold an index in 0..n-1. Never less than 1, so that a
    // single-slave build still gets a legal vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational base/mask address decoder. Every slot is compared in
// parallel. When regions overlap, the lowest slot index wins.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int                              N_SLAVES   = 5,
    parameter int                              IDX_W      = 3,
    parameter logic [N_SLAVES*BUS_ADDR_W-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*BUS_ADDR_W-1:0]  SLAVE_MASK = {N_SLAVES{32'hFFFFFFFF}}
) (
    input  logic [BUS_ADDR_W-1:0] address,
    output logic [N_SLAVES-1:0]   hit,
    output logic [IDX_W-1:0]      idx,
    output logic                  miss
);

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_cmp
        assign hit[i] = (address & SLAVE_MASK[BUS_ADDR_W*i +: BUS_ADDR_W])
                        == SLAVE_BASE[BUS_ADDR_W*i +: BUS_ADDR_W];
    end

    // Priority encode: walking downward lets the lowest matching index win.
    always_comb begin
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) idx = IDX_W'(i);
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/bus_interconnect.sv
// Memory-bus interconnect: decodes the master address, drives a one-hot slave
// select, and returns the selected slave's data and ready. A decode miss becomes
// a one-cycle ready+fault. When `define BUS_TIMEOUT_EN is set, a 16-bit stall
// counter also turns a slave that stays silent into ready+fault.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int                              N_SLAVES       = 5,
    parameter logic [N_SLAVES*BUS_ADDR_W-1:0]  SLAVE_BASE     = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*BUS_ADDR_W-1:0]  SLAVE_MASK     = {N_SLAVES{32'hFFFFFFFF}},
    parameter int                              TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BUS_ADDR_W-1:0]          address_in,
    input  logic                           read_in,
    input  logic                           write_in,
    input  logic [BUS_MASK_W-1:0]          write_mask_in,
    input  logic [BUS_DATA_W-1:0]          write_value_in,
    output logic [BUS_DATA_W-1:0]          read_value_out,
    output logic                           ready_out,
    output logic                           fault_out,
    output logic [BUS_ADDR_W-1:0]          address_out,
    output logic [BUS_MASK_W-1:0]          write_mask_out,
    output logic [BUS_DATA_W-1:0]          write_value_out,
    output logic                           read_out,
    output logic [N_SLAVES-1:0]            sel_out,
    input  logic [N_SLAVES*BUS_DATA_W-1:0] read_value_in,
    input  logic [N_SLAVES-1:0]            ready_in
);

    localparam int IDX_W = clog2_min1(N_SLAVES);

    bus_state_t              state;
    logic [IDX_W-1:0]        idx_q;
    logic [N_SLAVES-1:0]     dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_miss;
    logic                    slv_rdy;
    logic [BUS_DATA_W-1:0]   slv_data;
    logic [N_SLAVES-1:0]     idx_onehot;
    logic                    active;
    logic                    tmo;
    logic                    sel_live;

    bus_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .address (address_in),
        .hit     (dec_hit),
        .idx     (dec_idx),
        .miss    (dec_miss)
    );

    // The hit vector is not needed here because the index carries the decision.
    logic unused_dec_hit;
    assign unused_dec_hit = ^dec_hit;

    // Pick out the latched slave's ready and data. The loop avoids indexing
    // past N_SLAVES when N_SLAVES is not a power of two.
    always_comb begin
        slv_rdy    = 1'b0;
        slv_data   = '0;
        idx_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slv_rdy       = ready_in[i];
                slv_data      = read_value_in[BUS_DATA_W*i +: BUS_DATA_W];
                idx_onehot[i] = 1'b1;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Stall counter: held at zero while idle, so it is clear on entry to
    // ACTIVE. It counts each ACTIVE cycle that has no ready.
    always_ff @(posedge clk) begin
        if (reset)                          tmo_cnt <= '0;
        else if (state != ACTIVE)           tmo_cnt <= '0;
        else if (!slv_rdy)                  tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Ready in the expiry cycle takes priority over the timeout.
    assign tmo = (state == ACTIVE) && !slv_rdy && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    assign active   = (state == ACTIVE);
    assign sel_live = active && !tmo;

    // Master-side response and slave-side strobes. A slave is never written
    // unless it is actually selected.
    always_comb begin
        sel_out         = sel_live ? idx_onehot : '0;
        address_out     = address_in;
        write_value_out = write_value_in;
        write_mask_out  = sel_live ? write_mask_in : '0;
        read_out        = sel_live && read_in;
        ready_out       = (active && (slv_rdy || tmo)) || (state == ERROR);
        fault_out       = tmo || (state == ERROR);
        read_value_out  = (active && slv_rdy) ? slv_data : '0;
    end

    // Transaction FSM: decode in IDLE, wait in ACTIVE, fault for one cycle in ERROR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_in || write_in) begin
                        if (dec_miss) begin
                            state <= ERROR;
                        end else begin
                            state <= ACTIVE;
                            idx_q <= dec_idx;
                        end
                    end
                end
                ACTIVE:  if (slv_rdy || tmo) state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Randomized bench for bus_interconnect. A transaction-level model predicts,
// for each cycle, which slave is selected and when the single ready pulse
// appears (with or without a fault).
module tb_bus_interconnect;

    localparam int N  = 5;
    localparam int TO = 8;
    // slots: 0 RAM, 1 periph @0x0001xxxx, 2 UART, 3 overlaps slot 1, 4 timer
    localparam logic [N*32-1:0] BASE = {32'h0003_0000, 32'h0001_0000, 32'h0002_0000,
                                        32'h0001_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000,
                                        32'hFFFF_0000, 32'hFFFF_0000};

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     address_in, write_value_in, read_value_out, address_out, write_value_out;
    logic            read_in, write_in, ready_out, fault_out, read_out;
    logic [3:0]      write_mask_in, write_mask_out;
    logic [N-1:0]    sel_out, ready_in;
    logic [N*32-1:0] read_value_in;

    int total = 0;
    int bad   = 0;

    // Address map, stated as a plain table.
    logic [31:0] m_base [N] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                                32'h0001_0000, 32'h0003_0000};
    logic [31:0] m_mask [N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                32'hFFFF_F000, 32'hFFFF_0000};

    bus_interconnect #(
        .N_SLAVES       (N),
        .SLAVE_BASE     (BASE),
        .SLAVE_MASK     (MASK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .address_in      (address_in),
        .read_in         (read_in),
        .write_in        (write_in),
        .write_mask_in   (write_mask_in),
        .write_value_in  (write_value_in),
        .read_value_out  (read_value_out),
        .ready_out       (ready_out),
        .fault_out       (fault_out),
        .address_out     (address_out),
        .write_mask_out  (write_mask_out),
        .write_value_out (write_value_out),
        .read_out        (read_out),
        .sel_out         (sel_out),
        .read_value_in   (read_value_in),
        .ready_in        (ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_target(input logic [31:0] addr);
        for (int i = 0; i < N; i++)
            if ((addr & m_mask[i]) == m_base[i]) return i;
        return -1;
    endfunction

    task automatic idle_inputs();
        read_in = 0; write_in = 0; write_mask_in = 0;
        address_in = $urandom; write_value_in = $urandom;
        ready_in = N'($urandom); read_value_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // One master transaction, entered and left at posedge+1. The slave answers
    // after wt wait states; other slaves produce random ready/data noise.
    task automatic txn(input logic [31:0] addr, input bit rd, input logic [3:0] wm,
                       input int wt, input logic [31:0] rdat, input bit gap);
        int tgt;
        int done_k;
        bit tfault;
        logic [31:0] wdat;
        logic [N-1:0] exp_sel;
        bit exp_rdy, exp_flt;
        tgt = model_target(addr);
        wdat = $urandom;
        tfault = 0;
        if (tgt < 0) done_k = 2;
        else begin
            done_k = wt + 2;
`ifdef BUS_TIMEOUT_EN
            if (wt >= TO) begin done_k = TO + 1; tfault = 1; end
`endif
        end
        for (int k = 1; k <= done_k; k++) begin
            address_in = addr; read_in = rd; write_in = !rd;
            write_mask_in = wm; write_value_in = wdat;
            ready_in = N'($urandom);
            read_value_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (tgt >= 0) begin
                ready_in[tgt] = (k == wt + 2);
                read_value_in[32*tgt +: 32] = rdat;
            end
            @(negedge clk);
            exp_sel = '0;
            if (tgt >= 0 && k >= 2 && !(tfault && k == done_k)) exp_sel[tgt] = 1'b1;
            exp_rdy = (k == done_k);
            exp_flt = exp_rdy && (tgt < 0 || tfault);
            chk("sel",   64'(sel_out),   64'(exp_sel));
            chk("ready", 64'(ready_out), 64'(exp_rdy));
            chk("fault", 64'(fault_out), 64'(exp_flt));
            chk("rdata", 64'(read_value_out), (exp_rdy && !exp_flt) ? 64'(rdat) : 64'd0);
            chk("wmask", 64'(write_mask_out), (exp_sel != 0) ? 64'(wm) : 64'd0);
            chk("rd_out", 64'(read_out), (exp_sel != 0) ? 64'(rd) : 64'd0);
            chk("addr_fw", 64'(address_out), 64'(addr));
            chk("wdat_fw", 64'(write_value_out), 64'(wdat));
            @(posedge clk); #1;
        end
        if (gap) begin
            idle_inputs();
            @(negedge clk);
            chk("gap_ready", 64'(ready_out), 64'd0);
            chk("gap_sel",   64'(sel_out),   64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset with an active-looking request and noise: master outputs must stay quiet.
        reset = 1; read_in = 1; write_in = 0; write_mask_in = 4'hF;
        address_in = 32'h10; write_value_in = 0; ready_in = '1; read_value_in = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel",   64'(sel_out),        64'd0);
        chk("rst_ready", 64'(ready_out),      64'd0);
        chk("rst_fault", 64'(fault_out),      64'd0);
        chk("rst_rd",    64'(read_out),       64'd0);
        chk("rst_wmask", 64'(write_mask_out), 64'd0);
        chk("rst_rdata", 64'(read_value_out), 64'd0);
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        @(posedge clk); #1;

        txn(32'h0000_0010, 1, 4'h0, 0, 32'hDEAD_BEEF, 1);  // zero-wait RAM read
        txn(32'h0002_0004, 1, 4'h0, 3, $urandom, 1);       // UART with 3 waits
        txn(32'h0005_0000, 0, 4'hF, 0, $urandom, 1);       // miss write
        txn(32'h0001_0000, 1, 4'h0, 1, $urandom, 0);       // overlap -> slot 1, no gap
        txn(32'h0001_0010, 1, 4'h0, 0, $urandom, 1);       // back-to-back
        txn(32'h0000_0100, 0, 4'h5, 2, $urandom, 1);       // RAM write
`ifdef BUS_TIMEOUT_EN
        txn(32'h0003_0000, 1, 4'h0, TO,     $urandom, 1);  // timer never answers
        txn(32'h0003_0000, 1, 4'h0, TO - 1, $urandom, 1);  // ready on expiry cycle
`endif

        // Reset in the second ACTIVE cycle of a stalled access.
        address_in = 32'h0003_0008; read_in = 1; write_in = 0; write_mask_in = 0;
        ready_in = '0;
        @(posedge clk); #1;                 // IDLE -> ACTIVE
        @(posedge clk); #1;                 // ACTIVE cycle 2
        reset = 1;
        @(negedge clk);
        chk("rmid_ready", 64'(ready_out), 64'd0);
        @(posedge clk); #1;
        reset = 0; read_in = 0; ready_in = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rmid_sel",   64'(sel_out),   64'd0);
            chk("rmid_ready", 64'(ready_out), 64'd0);
            @(posedge clk); #1;
        end
        txn(32'h0003_0008, 1, 4'h0, 1, $urandom, 1);

        // Randomized traffic: mostly mapped regions, with some misses.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int wmax;
            case ($urandom_range(0, 5))
                0: a = 32'h0000_0000 | 32'($urandom_range(0, 16'hFFFF));
                1: a = 32'h0001_0000 | 32'($urandom_range(0, 16'h1FFF));
                2: a = 32'h0002_0000 | 32'($urandom_range(0, 16'hFFFF));
                3: a = 32'h0003_0000 | 32'($urandom_range(0, 16'hFFFF));
                default: a = $urandom;
            endcase
`ifdef BUS_TIMEOUT_EN
            wmax = TO + 2;
`else
            wmax = 5;
`endif
            txn(a, 1'($urandom), 4'($urandom), $urandom_range(0, wmax), $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
